// File: rtl/regfile_wb_arbiter_if.sv
// ============================================================================
//  Module   : regfile_wb_arbiter_if
//  Brief    : Write-back requester and register-file write bus for regfile_wb_arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface regfile_wb_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic              Req0Valid, Req1Valid, Req2Valid;
  logic              Req0Ready, Req1Ready, Req2Ready;
  logic [AW-1:0]     Req0Rd, Req1Rd, Req2Rd;
  logic [DW-1:0]     Req0Data, Req1Data, Req2Data;
  logic [AW-1:0]     RD;
  logic [DW-1:0]     WData;
  logic              RegWr;
  logic [2**AW-1:0]  Busy;

  modport master (
    output Req0Valid, Req1Valid, Req2Valid,
    output Req0Rd, Req1Rd, Req2Rd,
    output Req0Data, Req1Data, Req2Data,
    input  Req0Ready, Req1Ready, Req2Ready,
    input  RD, WData, RegWr, Busy
  );

  modport slave (
    input  Req0Valid, Req1Valid, Req2Valid,
    input  Req0Rd, Req1Rd, Req2Rd,
    input  Req0Data, Req1Data, Req2Data,
    output Req0Ready, Req1Ready, Req2Ready,
    output RD, WData, RegWr, Busy
  );
endinterface

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Brief    : Three-port write-back arbiter for the register-file write port with
//             per-rd ordering and pending-write scoreboard. Optional WB_STATS_EN
//             adds the ConflictCnt statistics counter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic                  Clk,
  input  logic                  Reset,
`ifdef WB_STATS_EN
  output logic [15:0]           ConflictCnt,
`endif
  regfile_wb_arbiter_if.slave   bus
);

  localparam int NREG = 2**AW;

  logic [2:0]     in_valid;
  logic [AW-1:0]  in_rd   [3];
  logic [DW-1:0]  in_data [3];

  assign in_valid   = {bus.Req2Valid, bus.Req1Valid, bus.Req0Valid};
  assign in_rd[0]   = bus.Req0Rd;
  assign in_rd[1]   = bus.Req1Rd;
  assign in_rd[2]   = bus.Req2Rd;
  assign in_data[0] = bus.Req0Data;
  assign in_data[1] = bus.Req1Data;
  assign in_data[2] = bus.Req2Data;

  logic [2:0]      valid_q, valid_d;
  logic [AW-1:0]   rd_q   [3];
  logic [AW-1:0]   rd_d   [3];
  logic [DW-1:0]   data_q [3];
  logic [DW-1:0]   data_d [3];
  logic [2:0]      older_q [3];  // older_q[i][j]: entry i was accepted before entry j
  logic [2:0]      older_d [3];
  logic            rr_q, rr_d;   // 0 favours port 0, 1 favours port 1
  logic [NREG-1:0] busy_q, busy_d;

  logic [2:0]      blocked, elig, grant, ready, accept;
  logic [AW-1:0]   sel_rd;
  logic [DW-1:0]   sel_data;

  // An entry is blocked while an older valid entry targets the same non-zero rd.
  always_comb begin
    blocked = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (i != j && valid_q[j] && older_q[j][i] &&
            rd_q[j] == rd_q[i] && rd_q[i] != '0)
          blocked[i] = 1'b1;
      end
    end
    elig = valid_q & ~blocked;
    if (elig[2])
      grant = 3'b100;
    else if (elig[1:0] == 2'b11)
      grant = rr_q ? 3'b010 : 3'b001;
    else
      grant = {1'b0, elig[1:0]};
  end

  assign ready  = ~valid_q | grant;
  assign accept = in_valid & ready;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < 3; i++) begin
      if (grant[i]) begin
        sel_rd   = rd_q[i];
        sel_data = data_q[i];
      end
    end
  end

  assign bus.Req0Ready = ready[0];
  assign bus.Req1Ready = ready[1];
  assign bus.Req2Ready = ready[2];
  assign bus.RD        = sel_rd;
  assign bus.WData     = sel_data;
  assign bus.RegWr     = (|grant) && (sel_rd != '0);
  assign bus.Busy      = busy_q;

  // Same-edge acceptances rank port 1 oldest, then port 0, then port 2.
  always_comb begin
    valid_d = (valid_q & ~grant) | accept;
    rr_d    = grant[0] ? 1'b1 : (grant[1] ? 1'b0 : rr_q);
    busy_d  = '0;
    for (int i = 0; i < 3; i++) begin
      rd_d[i]   = accept[i] ? in_rd[i]   : rd_q[i];
      data_d[i] = accept[i] ? in_data[i] : data_q[i];
      for (int j = 0; j < 3; j++) begin
        if (i == j)
          older_d[i][j] = 1'b0;
        else if (accept[i] && accept[j])
          older_d[i][j] = (i == 1) || (i == 0 && j == 2);
        else if (accept[i])
          older_d[i][j] = 1'b0;
        else if (accept[j])
          older_d[i][j] = 1'b1;
        else
          older_d[i][j] = older_q[i][j];
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (valid_d[i])
        busy_d[rd_d[i]] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid_q <= '0;
      rr_q    <= 1'b0;
      busy_q  <= '0;
      for (int i = 0; i < 3; i++) begin
        rd_q[i]    <= '0;
        data_q[i]  <= '0;
        older_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      rr_q    <= rr_d;
      busy_q  <= busy_d;
      for (int i = 0; i < 3; i++) begin
        rd_q[i]    <= rd_d[i];
        data_q[i]  <= data_d[i];
        older_q[i] <= older_d[i];
      end
    end
  end

`ifdef WB_STATS_EN
  logic        multi_valid;
  logic [15:0] conflict_q;

  assign multi_valid = (valid_q[0] & valid_q[1]) | (valid_q[0] & valid_q[2]) |
                       (valid_q[1] & valid_q[2]);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      conflict_q <= '0;
    else if (multi_valid && conflict_q != 16'hFFFF)
      conflict_q <= conflict_q + 16'd1;
  end

  assign ConflictCnt = conflict_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
//  Module   : tb_regfile_wb_arbiter
//  Brief    : Self-checking bench for regfile_wb_arbiter (directed + random).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

  logic Clk;
  logic Reset;
  int   n_cmp;
  int   n_fail;

  regfile_wb_arbiter_if #(.DW(32), .AW(5)) bus ();

`ifdef WB_STATS_EN
  logic [15:0] ConflictCnt;
  regfile_wb_arbiter #(.DW(32), .AW(5)) dut (
    .Clk(Clk), .Reset(Reset), .ConflictCnt(ConflictCnt), .bus(bus)
  );
`else
  regfile_wb_arbiter #(.DW(32), .AW(5)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus)
  );
`endif

  always #5 Clk = ~Clk;

  task automatic set_req(input int p, input logic v, input logic [4:0] r, input logic [31:0] d);
    case (p)
      0: begin bus.Req0Valid = v; bus.Req0Rd = r; bus.Req0Data = d; end
      1: begin bus.Req1Valid = v; bus.Req1Rd = r; bus.Req1Data = d; end
      default: begin bus.Req2Valid = v; bus.Req2Rd = r; bus.Req2Data = d; end
    endcase
  endtask

  task automatic idle();
    for (int p = 0; p < 3; p++) set_req(p, 1'b0, 5'd0, 32'd0);
  endtask

  function automatic logic [2:0] readies();
    return {bus.Req2Ready, bus.Req1Ready, bus.Req0Ready};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.RegWr !== 1'b0) begin n_fail++; $display("FAIL reset_regwr: got %b expected 0", bus.RegWr); end
    n_cmp++; if (bus.RD !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %0d expected 0", bus.RD); end
    n_cmp++; if (bus.WData !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %0h expected 0", bus.WData); end
    n_cmp++; if (bus.Busy !== 32'd0) begin n_fail++; $display("FAIL reset_busy: got %0h expected 0", bus.Busy); end
    n_cmp++; if (readies() !== 3'b111) begin n_fail++; $display("FAIL reset_ready: got %b expected 111", readies()); end
`ifdef WB_STATS_EN
    n_cmp++; if (ConflictCnt !== 16'd0) begin n_fail++; $display("FAIL reset_conflict: got %0d expected 0", ConflictCnt); end
`endif
  endtask

  task automatic test_single_alu();
    do_reset();
    set_req(0, 1'b1, 5'd5, 32'h1234);
    tick();
    idle();
    n_cmp++; if (bus.RegWr !== 1'b1) begin n_fail++; $display("FAIL alu_regwr: got %b expected 1", bus.RegWr); end
    n_cmp++; if (bus.RD !== 5'd5) begin n_fail++; $display("FAIL alu_rd: got %0d expected 5", bus.RD); end
    n_cmp++; if (bus.WData !== 32'h1234) begin n_fail++; $display("FAIL alu_wdata: got %0h expected 1234", bus.WData); end
    n_cmp++; if (bus.Busy !== 32'h20) begin n_fail++; $display("FAIL alu_busy: got %0h expected 20", bus.Busy); end
    tick();
    n_cmp++; if (bus.Busy !== 32'd0) begin n_fail++; $display("FAIL alu_busy_clr: got %0h expected 0", bus.Busy); end
    n_cmp++; if (bus.Req0Ready !== 1'b1) begin n_fail++; $display("FAIL alu_ready: got %b expected 1", bus.Req0Ready); end
    n_cmp++; if (bus.RegWr !== 1'b0) begin n_fail++; $display("FAIL alu_idle_regwr: got %b expected 0", bus.RegWr); end
  endtask

  task automatic test_x0();
    do_reset();
    set_req(1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    tick();
    idle();
    n_cmp++; if (bus.RegWr !== 1'b0) begin n_fail++; $display("FAIL x0_regwr: got %b expected 0", bus.RegWr); end
    n_cmp++; if (bus.Busy !== 32'd0) begin n_fail++; $display("FAIL x0_busy: got %0h expected 0", bus.Busy); end
    n_cmp++; if (bus.Req1Ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %b expected 1", bus.Req1Ready); end
    tick();
    n_cmp++; if (bus.RegWr !== 1'b0) begin n_fail++; $display("FAIL x0_after_regwr: got %b expected 0", bus.RegWr); end
    n_cmp++; if (readies() !== 3'b111) begin n_fail++; $display("FAIL x0_freed: got %b expected 111", readies()); end
  endtask

  task automatic test_round_robin();
    do_reset();
    set_req(0, 1'b1, 5'd3, 32'hA0);
    set_req(1, 1'b1, 5'd4, 32'hB0);
    tick();
    for (int k = 0; k < 8; k++) begin
      logic [4:0] erd;
      logic [1:0] erdy;
      erd  = (k % 2 == 0) ? 5'd3 : 5'd4;
      erdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++; if (bus.RegWr !== 1'b1 || bus.RD !== erd) begin n_fail++; $display("FAIL rr_grant[%0d]: got wr=%b rd=%0d expected wr=1 rd=%0d", k, bus.RegWr, bus.RD, erd); end
      n_cmp++; if (readies() !== {1'b1, erdy}) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, readies(), {1'b1, erdy}); end
      tick();
    end
    idle();
    repeat (3) tick();
  endtask

  task automatic test_same_rd_order();
    do_reset();
    set_req(1, 1'b1, 5'd7, 32'hAAAA);
    set_req(0, 1'b1, 5'd7, 32'hBBBB);
    tick();
    idle();
    n_cmp++; if (bus.RegWr !== 1'b1 || bus.RD !== 5'd7 || bus.WData !== 32'hAAAA) begin n_fail++; $display("FAIL order_first: got wr=%b rd=%0d data=%0h expected 1/7/aaaa", bus.RegWr, bus.RD, bus.WData); end
    n_cmp++; if (bus.Busy !== 32'h80) begin n_fail++; $display("FAIL order_busy: got %0h expected 80", bus.Busy); end
    tick();
    n_cmp++; if (bus.RegWr !== 1'b1 || bus.RD !== 5'd7 || bus.WData !== 32'hBBBB) begin n_fail++; $display("FAIL order_second: got wr=%b rd=%0d data=%0h expected 1/7/bbbb", bus.RegWr, bus.RD, bus.WData); end
    tick();
    n_cmp++; if (bus.RegWr !== 1'b0 || bus.Busy !== 32'd0) begin n_fail++; $display("FAIL order_drained: got wr=%b busy=%0h expected 0/0", bus.RegWr, bus.Busy); end
  endtask

  task automatic test_debug_priority();
    do_reset();
    set_req(0, 1'b1, 5'd10, 32'h10);
    set_req(2, 1'b1, 5'd9, 32'h9);
    tick();
    idle();
    n_cmp++; if (bus.RD !== 5'd9 || bus.WData !== 32'h9) begin n_fail++; $display("FAIL dbg_first: got rd=%0d data=%0h expected 9/9", bus.RD, bus.WData); end
    tick();
    n_cmp++; if (bus.RD !== 5'd10 || bus.WData !== 32'h10) begin n_fail++; $display("FAIL dbg_second: got rd=%0d data=%0h expected 10/10", bus.RD, bus.WData); end
    tick();
    do_reset();
    set_req(0, 1'b1, 5'd9, 32'h90);
    set_req(2, 1'b1, 5'd20, 32'h20);
    tick();
    idle();
    set_req(2, 1'b1, 5'd9, 32'h29);
    n_cmp++; if (bus.RD !== 5'd20 || bus.Req2Ready !== 1'b1) begin n_fail++; $display("FAIL dbg_pre: got rd=%0d rdy2=%b expected 20/1", bus.RD, bus.Req2Ready); end
    tick();
    idle();
    n_cmp++; if (bus.RD !== 5'd9 || bus.WData !== 32'h90) begin n_fail++; $display("FAIL dbg_older_first: got rd=%0d data=%0h expected 9/90", bus.RD, bus.WData); end
    tick();
    n_cmp++; if (bus.RD !== 5'd9 || bus.WData !== 32'h29) begin n_fail++; $display("FAIL dbg_younger: got rd=%0d data=%0h expected 9/29", bus.RD, bus.WData); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, 1'b1, 5'd1, 32'h11);
    set_req(1, 1'b1, 5'd2, 32'h22);
    set_req(2, 1'b1, 5'd3, 32'h33);
    tick();
    idle();
    n_cmp++; if (bus.Busy !== 32'hE) begin n_fail++; $display("FAIL mid_full_busy: got %0h expected e", bus.Busy); end
    #2;
    Reset = 1'b1;
    #1;
    n_cmp++; if (bus.RegWr !== 1'b0 || bus.RD !== 5'd0 || bus.WData !== 32'd0) begin n_fail++; $display("FAIL mid_outputs: got wr=%b rd=%0d data=%0h expected 0/0/0", bus.RegWr, bus.RD, bus.WData); end
    n_cmp++; if (bus.Busy !== 32'd0) begin n_fail++; $display("FAIL mid_busy: got %0h expected 0", bus.Busy); end
`ifdef WB_STATS_EN
    n_cmp++; if (ConflictCnt !== 16'd0) begin n_fail++; $display("FAIL mid_conflict: got %0d expected 0", ConflictCnt); end
`endif
    #2;
    Reset = 1'b0;
    tick();
    n_cmp++; if (bus.RegWr !== 1'b0 || bus.Busy !== 32'd0 || readies() !== 3'b111) begin n_fail++; $display("FAIL mid_after: got wr=%b busy=%0h rdy=%b expected 0/0/111", bus.RegWr, bus.Busy, readies()); end
  endtask

  // Reference model: entries carry a global acceptance sequence number.
  task automatic test_random();
    logic        mv   [3];
    logic [4:0]  mrd  [3];
    logic [31:0] mdat [3];
    int          mseq [3];
    logic        iv   [3];
    logic [4:0]  ir   [3];
    logic [31:0] id   [3];
    int          order [3];
    int seq, mrr, mcnt, g, nv;
    logic        elig [3];
    logic [2:0]  e_rdy;
    logic        e_wr;
    logic [4:0]  e_rd;
    logic [31:0] e_dat, e_busy;
    order = '{1, 0, 2};
    do_reset();
    for (int i = 0; i < 3; i++) begin mv[i] = 1'b0; mrd[i] = '0; mdat[i] = '0; mseq[i] = 0; end
    seq = 0; mrr = 0; mcnt = 0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 3; p++) begin
        iv[p] = ($urandom_range(0, 99) < 60);
        ir[p] = 5'($urandom_range(0, 3));
        id[p] = $urandom;
        set_req(p, iv[p], ir[p], id[p]);
      end
      for (int i = 0; i < 3; i++) begin
        elig[i] = mv[i];
        for (int j = 0; j < 3; j++)
          if (j != i && mv[j] && mrd[j] == mrd[i] && mrd[i] != 0 && mseq[j] < mseq[i]) elig[i] = 1'b0;
      end
      if (elig[2]) g = 2;
      else if (elig[0] && elig[1]) g = mrr;
      else if (elig[0]) g = 0;
      else if (elig[1]) g = 1;
      else g = -1;
      e_wr = 1'b0; e_rd = '0; e_dat = '0; e_busy = '0; nv = 0;
      if (g >= 0) begin e_rd = mrd[g]; e_dat = mdat[g]; e_wr = (mrd[g] != 0); end
      for (int i = 0; i < 3; i++) begin
        e_rdy[i] = !mv[i] || (g == i);
        if (mv[i]) begin nv++; if (mrd[i] != 0) e_busy[mrd[i]] = 1'b1; end
      end
      n_cmp++; if (bus.RegWr !== e_wr || bus.RD !== e_rd || bus.WData !== e_dat) begin n_fail++; $display("FAIL rnd_write[%0d]: got wr=%b rd=%0d data=%0h expected wr=%b rd=%0d data=%0h", c, bus.RegWr, bus.RD, bus.WData, e_wr, e_rd, e_dat); end
      n_cmp++; if (bus.Busy !== e_busy) begin n_fail++; $display("FAIL rnd_busy[%0d]: got %0h expected %0h", c, bus.Busy, e_busy); end
      n_cmp++; if (readies() !== e_rdy) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b expected %b", c, readies(), e_rdy); end
`ifdef WB_STATS_EN
      n_cmp++; if (ConflictCnt !== 16'(mcnt)) begin n_fail++; $display("FAIL rnd_conflict[%0d]: got %0d expected %0d", c, ConflictCnt, mcnt); end
`endif
      if (nv >= 2 && mcnt < 65535) mcnt++;
      if (g >= 0) mv[g] = 1'b0;
      if (g == 0) mrr = 1; else if (g == 1) mrr = 0;
      for (int k = 0; k < 3; k++) begin
        if (iv[order[k]] && e_rdy[order[k]]) begin
          mv[order[k]] = 1'b1; mrd[order[k]] = ir[order[k]];
          mdat[order[k]] = id[order[k]]; mseq[order[k]] = seq; seq++;
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    Clk = 1'b0;
    Reset = 1'b1;
    n_cmp = 0;
    n_fail = 0;
    idle();
    test_reset();
    test_single_alu();
    test_x0();
    test_round_robin();
    test_same_rd_order();
    test_debug_priority();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (RD, WData, RegWr) between three write-back requesters: ALU (port 0), load unit (port 1) and debug/host (port 2).
- Each requester has a one-entry holding buffer with a valid/ready handshake.
- The block issues at most one write per cycle, preserves write order per destination register, and exports a pending-write scoreboard for hazard stalls.
- Sits between the execute/memory stages and the register file.

Parameters:
- DW, 32, data width of the write data.
- AW, 5, register address width; 2**AW registers, register 0 hardwired to zero.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Req0Valid / Req1Valid / Req2Valid  input  1 each  requester has a write to offer.
- Req0Ready / Req1Ready / Req2Ready  output  1 each  requester's buffer can accept.
- Req0Rd / Req1Rd / Req2Rd  input  AW each  destination register.
- Req0Data / Req1Data / Req2Data  input  DW each  write data.
- RD  output  AW  register-file write address.
- WData  output  DW  register-file write data.
- RegWr  output  1  register-file write enable.
- Busy  output  2**AW  bit i=1 while a buffered write to register i is pending.
- ConflictCnt  output  16  only when WB_STATS_EN is defined; see Optional Feature.

Behaviour:
- Buffers: one entry per port, each holding {valid, rd, data, age stamp}.
- Ready: ReqNReady = !bufN.valid, or bufN is committing this cycle (pass-through refill allowed).
- Accept: acceptance occurs at a Clk edge when Valid && Ready.
- Latency: data accepted at edge N appears on RD/WData/RegWr during cycle N+1 at the earliest. It reaches the register file at edge N+1 if granted.
- Drive: RD, WData and RegWr are combinational from the granted buffer. If no grant: RegWr=0, RD=0, WData=0.
- Register 0: a buffered write with rd==0 is granted normally, but RegWr=0 for that cycle. The buffer is still freed.
- Priority: port 2 (debug) has the highest priority. Ports 0 and 1 are round-robin; the pointer toggles to the other port after each port-0/1 grant.
- Ordering: if two valid buffers hold the same non-zero rd, the older entry (smaller age stamp) must be granted first. This overrides both round-robin and debug priority. Same-cycle acceptances to the same rd: port 1 is older than port 0, and port 0 is older than port 2.
- Age stamp: 2-bit per-entry counter, or equivalent pairwise order bits. Only the relative order among the 3 entries matters.
- Busy: Busy[i] = OR over valid buffers with rd==i. Busy[0]=0 always. Busy is registered state; it clears in the cycle after the commit edge.
- Grant: exactly one buffer is freed per cycle when any buffer is valid. The freed entry is invalidated at that edge unless refilled by the same edge.
- Reset: any time, including mid-operation.
  - All buffers are invalidated and pending writes are dropped.
  - Round-robin pointer = port 0.
  - RegWr=0, RD=0, WData=0, Busy=0.
  - All ReqNReady=1 the cycle after Reset deasserts (combinationally 1 while buffers are empty).
  - ConflictCnt=0.
- No combinational path from ReqNValid to ReqNReady.

Optional Feature:
- Macro: WB_STATS_EN.
- Defined: ConflictCnt counts cycles in which two or more buffers are valid, i.e. a requester waited. Increments by 1 per such cycle, saturates at 16'hFFFF, and is cleared by Reset.
- Undefined: the ConflictCnt port and counter are absent; the rest of the behaviour is identical.

Test Plan:
- Single ALU write: Req0 rd=5, data=0x1234 accepted at edge N. Cycle N+1: RegWr=1, RD=5, WData=0x1234, Busy[5]=1. After edge N+1: Busy[5]=0, Req0Ready=1.
- Write to x0: Req1 rd=0, data=0xFFFF_FFFF. The grant cycle shows RegWr=0, the buffer frees, and Busy stays 0.
- Contention round-robin: Req0 and Req1 are held valid every cycle with distinct rds (3 and 4). Grants alternate 0,1,0,1 and each sustains one write per 2 cycles.
- Same-rd ordering: Req1 rd=7 data=A and Req0 rd=7 data=B accepted at the same edge. Commits in order A then B; the final value of x7 is B regardless of the pointer.
- Debug priority versus ordering:
  - Req2 rd=9 with Req0 rd=10 pending: Req2 is granted first.
  - Req0 rd=9 accepted one cycle before Req2 rd=9: Req0 commits first.
- Reset mid-operation: all three buffers are full when Reset pulses asynchronously mid-cycle. RegWr=0 and Busy=0 immediately; no write occurs at the next edge; ConflictCnt=0 (if enabled).
